rom_2port_arbiter: RTL and testbench

Shares the two read ports of a `rom_2port` lookup table among `NREQ` independent requesters, such as per-lane rule or hash-table fetch engines in the string-matching accelerator. Each cycle it grants up to two requests, one per ROM port, using round-robin arbitration. It drives the ROM addresses, tracks which requester owns each in-flight read across the fixed ROM latency, and returns the read data to that requester. There is no response backpressure.

---
 rtl/rom_2port_arbiter_pkg.sv | 17 +
 rtl/rom_2port_arbiter_if.sv | 26 ++
 rtl/rom_2port_arbiter_rr_pick2.sv | 61 ++++++
 rtl/rom_2port_arbiter.sv | 128 ++++++++++++
 tb/tb_rom_2port_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/rom_2port_arbiter_pkg.sv
// Shared types for the ROM port arbiter: in-flight read tag and index-width helpers.
package sme_mem_pkg;

    localparam int MAX_NREQ = 16;
    localparam int IDXW     = $clog2(MAX_NREQ);

    typedef struct packed {
        logic            vld;
        logic [IDXW-1:0] owner;
    } rom_tag_t;

    // Pointer width for an n-way arbiter; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_2port_arbiter_if.sv
// Requester-side and ROM-side signal bundle of the two-port ROM arbiter.
interface rom_2port_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 8
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*AWIDTH-1:0] req_addr;
    logic [NREQ-1:0]        req_ready;
    logic [AWIDTH-1:0]      rom_addr_a;
    logic [AWIDTH-1:0]      rom_addr_b;
    logic [DWIDTH-1:0]      rom_qa;
    logic [DWIDTH-1:0]      rom_qb;
    logic [NREQ-1:0]        resp_valid;
    logic [NREQ*DWIDTH-1:0] resp_data;

    modport slave (
        input  req_valid, req_addr, rom_qa, rom_qb,
        output req_ready, rom_addr_a, rom_addr_b, resp_valid, resp_data
    );

    modport master (
        output req_valid, req_addr, rom_qa, rom_qb,
        input  req_ready, rom_addr_a, rom_addr_b, resp_valid, resp_data
    );
endinterface

// File: rtl/rom_2port_arbiter_rr_pick2.sv
// Combinational round-robin picker returning the first two requesters at or after ptr.
module rr_pick2
    import sme_mem_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            win_a_vld,
    output logic [PW-1:0]   win_a_idx,
    output logic            win_b_vld,
    output logic [PW-1:0]   win_b_idx,
    output logic [PW-1:0]   next_ptr
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [PW:0]       rot_base;
    logic [PW-1:0]     win_a_off;
    logic [PW-1:0]     win_b_off;
    logic [PW-1:0]     last_idx;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW-1:0] off);
        logic [PW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
        end
        return sum[PW-1:0];
    endfunction

    // Bit k of req_rot is requester (ptr + k) mod NREQ.
    assign req_dbl  = {req, req};
    assign rot_base = {1'b0, ptr};
    assign req_rot  = req_dbl[rot_base +: NREQ];

    always_comb begin
        win_a_vld = 1'b0;
        win_a_off = '0;
        win_b_vld = 1'b0;
        win_b_off = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_rot[k]) begin
                if (!win_a_vld) begin
                    win_a_vld = 1'b1;
                    win_a_off = PW'(k);
                end else if (!win_b_vld) begin
                    win_b_vld = 1'b1;
                    win_b_off = PW'(k);
                end
            end
        end
    end

    assign win_a_idx = wrap_add(ptr, win_a_off);
    assign win_b_idx = wrap_add(ptr, win_b_off);
    assign last_idx  = win_b_vld ? win_b_idx : win_a_idx;
    assign next_ptr  = win_a_vld ? wrap_add(last_idx, PW'(1)) : ptr;

endmodule

// File: rtl/rom_2port_arbiter.sv
// Shares both rom_2port read ports among NREQ requesters and routes data back by owner tag.
module rom_2port_arbiter
    import sme_mem_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 8,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    rom_2port_arbiter_if.slave bus
);

    localparam int PW = ptr_w(NREQ);

    logic [PW-1:0]          ptr_q, ptr_d;
    logic                   win_a_vld, win_b_vld;
    logic [PW-1:0]          win_a_idx, win_b_idx;
    logic [NREQ-1:0]        ready;
    logic [AWIDTH-1:0]      addr_a, addr_b;
    rom_tag_t               tag_a_now, tag_b_now;
    rom_tag_t               tag_a_al, tag_b_al;
    logic [NREQ-1:0]        resp_valid_q, resp_valid_d;
    logic [NREQ*DWIDTH-1:0] resp_data_q, resp_data_d;

    rr_pick2 #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .win_a_vld (win_a_vld),
        .win_a_idx (win_a_idx),
        .win_b_vld (win_b_vld),
        .win_b_idx (win_b_idx),
        .next_ptr  (ptr_d)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign ready[gi] = (win_a_vld && (win_a_idx == PW'(gi))) ||
                           (win_b_vld && (win_b_idx == PW'(gi)));
    end

    always_comb begin
        addr_a = '0;
        addr_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_a_vld && (win_a_idx == PW'(i))) begin
                addr_a = bus.req_addr[i*AWIDTH +: AWIDTH];
            end
            if (win_b_vld && (win_b_idx == PW'(i))) begin
                addr_b = bus.req_addr[i*AWIDTH +: AWIDTH];
            end
        end
    end

    always_comb begin
        tag_a_now.vld   = win_a_vld;
        tag_a_now.owner = IDXW'(win_a_idx);
        tag_b_now.vld   = win_b_vld;
        tag_b_now.owner = IDXW'(win_b_idx);
    end

    // The tag travels alongside the ROM read so data and owner line up on the same cycle.
    if (RD_LAT == 0) begin : g_lat0
        assign tag_a_al = tag_a_now;
        assign tag_b_al = tag_b_now;
    end else begin : g_latn
        rom_tag_t tag_a_q [RD_LAT];
        rom_tag_t tag_a_d [RD_LAT];
        rom_tag_t tag_b_q [RD_LAT];
        rom_tag_t tag_b_d [RD_LAT];

        always_comb begin
            tag_a_d[0] = tag_a_now;
            tag_b_d[0] = tag_b_now;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_a_d[s] = tag_a_q[s-1];
                tag_b_d[s] = tag_b_q[s-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tag_a_q <= '{default: '0};
                tag_b_q <= '{default: '0};
            end else begin
                tag_a_q <= tag_a_d;
                tag_b_q <= tag_b_d;
            end
        end

        assign tag_a_al = tag_a_q[RD_LAT-1];
        assign tag_b_al = tag_b_q[RD_LAT-1];
    end

    // Port A and B winners are always distinct, so at most one hit per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
        logic hit_a, hit_b;
        assign hit_a = tag_a_al.vld && (tag_a_al.owner == IDXW'(gi));
        assign hit_b = tag_b_al.vld && (tag_b_al.owner == IDXW'(gi));
        assign resp_valid_d[gi] = hit_a || hit_b;
        assign resp_data_d[gi*DWIDTH +: DWIDTH] =
            hit_a ? bus.rom_qa :
            hit_b ? bus.rom_qb :
                    resp_data_q[gi*DWIDTH +: DWIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rom_addr_a = addr_a;
    assign bus.rom_addr_b = addr_b;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_rom_2port_arbiter.sv
// Directed vector table plus reset and random-scoreboard sequences across RD_LAT 0/1/2 builds.
module tb_rom_2port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int NVEC = 11;
    localparam int NRND = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*AW-1:0] req_addr  = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_2port_arbiter_if #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) if0 ();
    rom_2port_arbiter_if #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) if1 ();
    rom_2port_arbiter_if #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) if2 ();

    rom_2port_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .RD_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    rom_2port_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    rom_2port_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.req_valid = req_valid;
    assign if0.req_addr  = req_addr;
    assign if1.req_valid = req_valid;
    assign if1.req_addr  = req_addr;
    assign if2.req_valid = req_valid;
    assign if2.req_addr  = req_addr;

    // ROM contents: ROM[k] = k ^ 8'h5A, with 0, 1 and 2 cycles of read latency.
    logic [DW-1:0] q1a, q1b, q2a0, q2b0, q2a1, q2b1;
    assign if0.rom_qa = if0.rom_addr_a ^ 8'h5A;
    assign if0.rom_qb = if0.rom_addr_b ^ 8'h5A;
    always @(posedge clk) begin
        q1a  <= if1.rom_addr_a ^ 8'h5A;
        q1b  <= if1.rom_addr_b ^ 8'h5A;
        q2a0 <= if2.rom_addr_a ^ 8'h5A;
        q2b0 <= if2.rom_addr_b ^ 8'h5A;
        q2a1 <= q2a0;
        q2b1 <= q2b0;
    end
    assign if1.rom_qa = q1a;
    assign if1.rom_qb = q1b;
    assign if2.rom_qa = q2a1;
    assign if2.rom_qb = q2b1;

    // rv/data: response produced by this row's grants once the ROM latency has elapsed.
    typedef struct {
        logic [3:0]  valid;
        logic [31:0] addr;
        logic [3:0]  ready;
        logic [7:0]  addr_a;
        logic [7:0]  addr_b;
        logic [1:0]  ptr;
        logic [3:0]  rv;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [NVEC];

    typedef struct {
        logic [7:0] data;
        int         step;
    } sb_t;

    sb_t sb_q [NREQ][$];
    int  wait_cnt [NREQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_rv(input int s, input int lat);
        int j;
        j = s - lat - 1;
        return (j < 0) ? 4'h0 : vecs[j].rv;
    endfunction

    function automatic logic [31:0] exp_data(input int s, input int lat);
        int j;
        j = s - lat - 1;
        return (j < 0) ? 32'h0 : vecs[j].data;
    endfunction

    initial begin
        vecs[0]  = '{4'b0100, 32'h0010_0000, 4'b0100, 8'h10, 8'h00, 2'd0, 4'b0100, 32'h004A_0000};
        vecs[1]  = '{4'b0100, 32'h0011_0000, 4'b0100, 8'h11, 8'h00, 2'd3, 4'b0100, 32'h004B_0000};
        vecs[2]  = '{4'b1001, 32'h2000_0030, 4'b1001, 8'h20, 8'h30, 2'd3, 4'b1001, 32'h7A4B_006A};
        vecs[3]  = '{4'b1000, 32'h2100_0000, 4'b1000, 8'h21, 8'h00, 2'd1, 4'b1000, 32'h7B4B_006A};
        vecs[4]  = '{4'b1111, 32'h4342_4140, 4'b0011, 8'h40, 8'h41, 2'd0, 4'b0011, 32'h7B4B_1B1A};
        vecs[5]  = '{4'b1111, 32'h5352_5150, 4'b1100, 8'h52, 8'h53, 2'd2, 4'b1100, 32'h0908_1B1A};
        vecs[6]  = '{4'b1111, 32'h6362_6160, 4'b0011, 8'h60, 8'h61, 2'd0, 4'b0011, 32'h0908_3B3A};
        vecs[7]  = '{4'b1111, 32'h7372_7170, 4'b1100, 8'h72, 8'h73, 2'd2, 4'b1100, 32'h2928_3B3A};
        vecs[8]  = '{4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 2'd0, 4'b0000, 32'h2928_3B3A};
        vecs[9]  = '{4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 2'd0, 4'b0000, 32'h2928_3B3A};
        vecs[10] = '{4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 8'h00, 2'd0, 4'b0000, 32'h2928_3B3A};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ptr", 32'(dut1.ptr_q), 32'h0);
        check("rst_ready", 32'(if1.req_ready), 32'h0);
        check("rst_addr_a", 32'(if1.rom_addr_a), 32'h0);
        check("rst_addr_b", 32'(if1.rom_addr_b), 32'h0);
        check("rst_rv", 32'({if0.resp_valid, if1.resp_valid, if2.resp_valid}), 32'h0);
        check("rst_data", if1.resp_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester, pointer wrap, full contention, drain.
        for (int s = 0; s < NVEC; s++) begin
            @(negedge clk);
            req_valid = vecs[s].valid;
            req_addr  = vecs[s].addr;
            #1;
            check($sformatf("v%0d_ready", s), 32'(if1.req_ready), 32'(vecs[s].ready));
            check($sformatf("v%0d_addr_a", s), 32'(if1.rom_addr_a), 32'(vecs[s].addr_a));
            check($sformatf("v%0d_addr_b", s), 32'(if1.rom_addr_b), 32'(vecs[s].addr_b));
            check($sformatf("v%0d_ptr", s), 32'(dut1.ptr_q), 32'(vecs[s].ptr));
            check($sformatf("v%0d_rv_lat0", s), 32'(if0.resp_valid), 32'(exp_rv(s, 0)));
            check($sformatf("v%0d_rv_lat1", s), 32'(if1.resp_valid), 32'(exp_rv(s, 1)));
            check($sformatf("v%0d_rv_lat2", s), 32'(if2.resp_valid), 32'(exp_rv(s, 2)));
            check($sformatf("v%0d_data_lat0", s), if0.resp_data, exp_data(s, 0));
            check($sformatf("v%0d_data_lat1", s), if1.resp_data, exp_data(s, 1));
            check($sformatf("v%0d_data_lat2", s), if2.resp_data, exp_data(s, 2));
            $display("vec %0d: valid=%b ready=%b addr_a=%h addr_b=%h rv0=%b rv1=%b rv2=%b",
                     s, req_valid, if1.req_ready, if1.rom_addr_a, if1.rom_addr_b,
                     if0.resp_valid, if1.resp_valid, if2.resp_valid);
        end

        // Reset the cycle after grants to requesters 0 and 1.
        @(negedge clk);
        req_valid = 4'b0011;
        req_addr  = 32'h0000_0201;
        #1;
        check("mid_ready", 32'(if1.req_ready), 32'h3);
        $display("mid: grant ready=%b", if1.req_ready);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("mid_rst_ptr", 32'(dut1.ptr_q), 32'h0);
            check("mid_rst_ready", 32'(if1.req_ready), 32'h0);
            check("mid_rst_addr", 32'({if1.rom_addr_a, if1.rom_addr_b}), 32'h0);
            check("mid_rst_rv", 32'({if0.resp_valid, if1.resp_valid, if2.resp_valid}), 32'h0);
            check("mid_rst_data", if1.resp_data | if0.resp_data | if2.resp_data, 32'h0);
            $display("mid: in reset rv1=%b ptr=%0d", if1.resp_valid, dut1.ptr_q);
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("mid_post_rv", 32'({if0.resp_valid, if1.resp_valid, if2.resp_valid}), 32'h0);
            check("mid_post_ptr", 32'(dut1.ptr_q), 32'h0);
            $display("mid: after reset rv0=%b rv1=%b rv2=%b", if0.resp_valid, if1.resp_valid, if2.resp_valid);
        end

        // Random traffic against a per-requester in-order scoreboard (RD_LAT=1 build).
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        for (int n = 0; n < NRND + 4; n++) begin
            @(negedge clk);
            if (n < NRND) begin
                req_valid = 4'($urandom_range(0, 15));
                req_addr  = $urandom;
            end else begin
                req_valid = '0;
            end
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (if1.resp_valid[i]) begin
                    if (sb_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd_spurious: requester %0d got %h expected no response", i,
                                 if1.resp_data[i*DW +: DW]);
                    end else begin
                        sb_t e;
                        e = sb_q[i].pop_front();
                        check($sformatf("rnd_data_r%0d", i), 32'(if1.resp_data[i*DW +: DW]), 32'(e.data));
                        check($sformatf("rnd_lat_r%0d", i), 32'(n - e.step), 32'd2);
                    end
                end
            end
            check("rnd_ready_subset", 32'(if1.req_ready & ~req_valid), 32'h0);
            check("rnd_grants_le2", 32'($countones(if1.req_ready) <= 2), 32'h1);
            for (int i = 0; i < NREQ; i++) begin
                if (if1.req_ready[i]) begin
                    sb_q[i].push_back('{data: req_addr[i*AW +: AW] ^ 8'h5A, step: n});
                    wait_cnt[i] = 0;
                end else if (req_valid[i]) begin
                    check($sformatf("rnd_starve_r%0d", i), 32'(wait_cnt[i]), 32'd0);
                    wait_cnt[i]++;
                end else begin
                    wait_cnt[i] = 0;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            check($sformatf("rnd_drain_r%0d", i), 32'(sb_q[i].size()), 32'd0);
        end
        $display("rnd: %0d cycles done", NRND);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
